alu_cmd_sequencer: RTL and testbench

Registered command front-end for the 16-bit combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues one command at a time to the ALU through registered operand/select outputs, captures the ALU result and flags, and holds them on a valid/ready result port. It owns divide-by-zero trapping so the ALU never has its `A/B` result consumed with B=0.

---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 16-bit ALU: buffers operand/opcode commands in a FIFO,
// issues them one at a time on registered ALU inputs and holds each result on a valid/ready port.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_a,
    input  logic [15:0]                in_b,
    input  logic [3:0]                 in_sel,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [15:0]                alu_a,
    output logic [15:0]                alu_b,
    output logic [3:0]                 alu_sel,
    input  logic [15:0]                alu_out,
    input  logic                       alu_carry,
    input  logic                       alu_ovf,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_data,
    output logic                       res_carry,
    output logic                       res_ovf,
    output logic                       res_div0,
    output logic [TAG_W-1:0]           res_tag,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [3:0] SEL_DIV = 4'b0011;

    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [3:0]       sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    state_t           state;
    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [TAG_W-1:0] tag_q;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
    assign in_ready   = (fifo_count != CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty && ((state == IDLE) || (state == HOLD && res_ready));
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, sel: in_sel, tag: in_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Divide-by-zero is trapped here so the ALU's quotient for B=0 is never reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            tag_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            res_div0  <= 1'b0;
            res_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a   <= head.a;
                        alu_b   <= head.b;
                        alu_sel <= head.sel;
                        tag_q   <= head.tag;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (alu_sel == SEL_DIV && alu_b == 16'h0000) begin
                        res_data  <= 16'hFFFF;
                        res_carry <= 1'b0;
                        res_ovf   <= 1'b0;
                        res_div0  <= 1'b1;
                    end else begin
                        res_data  <= alu_out;
                        res_carry <= alu_carry;
                        res_ovf   <= alu_ovf;
                        res_div0  <= 1'b0;
                    end
                    res_tag   <= tag_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            alu_a   <= head.a;
                            alu_b   <= head.b;
                            alu_sel <= head.sel;
                            tag_q   <= head.tag;
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU attached to its ALU port.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_sel;
    logic [3:0]  in_tag;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        alu_ovf;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_ovf;
    logic        res_div0;
    logic [3:0]  res_tag;
    logic [2:0]  fifo_count;
    logic        stub_en;

    int vectors;
    int miscompares;

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_ovf(res_ovf), .res_div0(res_div0),
        .res_tag(res_tag), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; divide by zero returns a loud pattern with flags set so a missed trap shows.
    always_comb begin
        logic [16:0] sum;
        sum       = '0;
        alu_out   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_sel)
            4'b0000: begin
                sum       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out   = sum[15:0];
                alu_carry = sum[16];
                alu_ovf   = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
            end
            4'b0011: begin
                if (alu_b == 16'h0000) begin
                    alu_out   = 16'hDEAD;
                    alu_carry = 1'b1;
                    alu_ovf   = 1'b1;
                end else begin
                    alu_out = alu_a / alu_b;
                end
            end
            default: alu_out = alu_a & alu_b;
        endcase
        if (stub_en) begin
            alu_out   = 16'h0000;
            alu_carry = 1'b1;
            alu_ovf   = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] sel, input logic [3:0] tag);
        in_valid = valid;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        stub_en     = 1'b0;
        res_ready   = 1'b0;
        rst         = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);

        // Reset values
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_res_tag", 32'(res_tag), 32'd0);
        rst = 1'b0;
        tick();

        // Single add: 3 + 4, tag 1
        res_ready = 1'b1;
        applyStimulus(1'b1, 16'h0003, 16'h0004, 4'b0000, 4'd1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        checkOutput("add_count_after_accept", 32'(fifo_count), 32'd1);
        checkOutput("add_valid_e0", 32'(res_valid), 32'd0);
        tick();
        checkOutput("add_alu_a", 32'(alu_a), 32'h0003);
        checkOutput("add_alu_b", 32'(alu_b), 32'h0004);
        checkOutput("add_alu_sel", 32'(alu_sel), 32'd0);
        checkOutput("add_count_after_issue", 32'(fifo_count), 32'd0);
        checkOutput("add_valid_e1", 32'(res_valid), 32'd0);
        tick();
        checkOutput("add_valid_e2", 32'(res_valid), 32'd1);
        checkOutput("add_data", 32'(res_data), 32'h0007);
        checkOutput("add_tag", 32'(res_tag), 32'd1);
        checkOutput("add_carry", 32'(res_carry), 32'd0);
        checkOutput("add_div0", 32'(res_div0), 32'd0);
        tick();
        checkOutput("add_valid_drop", 32'(res_valid), 32'd0);

        // Divide by zero followed by a legal divide
        applyStimulus(1'b1, 16'h1234, 16'h0000, 4'b0011, 4'd2);
        tick();
        applyStimulus(1'b1, 16'h0010, 16'h0004, 4'b0011, 4'd3);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        tick();
        checkOutput("div0_valid", 32'(res_valid), 32'd1);
        checkOutput("div0_data", 32'(res_data), 32'hFFFF);
        checkOutput("div0_flag", 32'(res_div0), 32'd1);
        checkOutput("div0_carry", 32'(res_carry), 32'd0);
        checkOutput("div0_ovf", 32'(res_ovf), 32'd0);
        checkOutput("div0_tag", 32'(res_tag), 32'd2);
        tick();
        checkOutput("div_valid_gap", 32'(res_valid), 32'd0);
        checkOutput("div_alu_a", 32'(alu_a), 32'h0010);
        tick();
        checkOutput("div_valid", 32'(res_valid), 32'd1);
        checkOutput("div_data", 32'(res_data), 32'h0004);
        checkOutput("div_flag", 32'(res_div0), 32'd0);
        checkOutput("div_tag", 32'(res_tag), 32'd3);
        tick();
        checkOutput("div_idle_valid", 32'(res_valid), 32'd0);
        checkOutput("div_idle_count", 32'(fifo_count), 32'd0);

        // Back-pressure fill: tags 0..4 accepted, tag 5 refused while full
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'(i), 16'(i + 1), 4'b0000, 4'(i));
            tick();
        end
        applyStimulus(1'b1, 16'd5, 16'd6, 4'b0000, 4'd5);
        checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
        checkOutput("bp_count_full", 32'(fifo_count), 32'd4);
        tick();
        tick();
        checkOutput("bp_count_still_full", 32'(fifo_count), 32'd4);
        checkOutput("bp_in_ready_still", 32'(in_ready), 32'd0);
        checkOutput("bp_hold_valid", 32'(res_valid), 32'd1);
        checkOutput("bp_hold_tag", 32'(res_tag), 32'd0);
        checkOutput("bp_hold_data", 32'(res_data), 32'h0001);
        res_ready = 1'b1;
        tick();
        checkOutput("bp_r1_valid", 32'(res_valid), 32'd0);
        checkOutput("bp_r1_count", 32'(fifo_count), 32'd3);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        checkOutput("bp_tag5_accepted_count", 32'(fifo_count), 32'd4);
        checkOutput("bp_t1_valid", 32'(res_valid), 32'd1);
        checkOutput("bp_t1_tag", 32'(res_tag), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            checkOutput("bp_gap_valid", 32'(res_valid), 32'd0);
            tick();
            checkOutput("bp_valid", 32'(res_valid), 32'd1);
            checkOutput("bp_tag", 32'(res_tag), 32'(k));
            checkOutput("bp_data", 32'(res_data), 32'(2 * k + 1));
        end
        tick();
        checkOutput("bp_end_valid", 32'(res_valid), 32'd0);
        checkOutput("bp_end_count", 32'(fifo_count), 32'd0);

        // Flag pass-through with the stubbed ALU, held under back-pressure
        res_ready = 1'b0;
        stub_en   = 1'b1;
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 4'b0000, 4'd6);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput("stub_valid", 32'(res_valid), 32'd1);
            checkOutput("stub_carry", 32'(res_carry), 32'd1);
            checkOutput("stub_ovf", 32'(res_ovf), 32'd0);
            checkOutput("stub_data", 32'(res_data), 32'h0000);
            checkOutput("stub_tag", 32'(res_tag), 32'd6);
            tick();
        end
        res_ready = 1'b1;
        tick();
        stub_en = 1'b0;
        checkOutput("stub_consumed", 32'(res_valid), 32'd0);

        // Reset while holding a result with a command still queued
        res_ready = 1'b0;
        applyStimulus(1'b1, 16'h0001, 16'h0001, 4'b0000, 4'd7);
        tick();
        applyStimulus(1'b1, 16'h0002, 16'h0002, 4'b0000, 4'd8);
        tick();
        applyStimulus(1'b1, 16'h0003, 16'h0003, 4'b0000, 4'd9);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        checkOutput("mid_hold_valid", 32'(res_valid), 32'd1);
        checkOutput("mid_hold_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_alu_a", 32'(alu_a), 32'd0);
        checkOutput("mid_rst_res_tag", 32'(res_tag), 32'd0);
        tick();
        rst       = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("post_rst_no_result", 32'(res_valid), 32'd0);
            checkOutput("post_rst_count", 32'(fifo_count), 32'd0);
        end
        applyStimulus(1'b1, 16'h0005, 16'h0006, 4'b0000, 4'd10);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        tick();
        checkOutput("post_rst_issue_valid", 32'(res_valid), 32'd0);
        tick();
        checkOutput("post_rst_valid", 32'(res_valid), 32'd1);
        checkOutput("post_rst_data", 32'(res_data), 32'h000B);
        checkOutput("post_rst_tag", 32'(res_tag), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
